video_timing_controller: RTL and testbench

//  Sequences the video IP's scan-out. Consumes the control/address register values from the

---
 rtl/video_pkg.sv | 25 ++
 rtl/video_raster_counter.sv | 60 ++++++
 rtl/video_timing_controller.sv | 164 ++++++++++++++++
 tb/tb_video_timing_controller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the video scan-out block: FSM state codes,
// control register bit positions and default 640x480 VGA timing.
package video_pkg;

  // Scan-out FSM states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Bit positions inside the ctrl register.
  localparam int CTRL_EN    = 0;
  localparam int CTRL_SWAP  = 1;
  localparam int CTRL_IRQEN = 2;

  // Default 640x480@60 timing, in pixel clocks and lines.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/video_raster_counter.sv
// Horizontal/vertical raster counters with wrap and frame-end detect.
// Exposes the next-state values so the caller can register decoded
// outputs that line up cycle-exactly with the counters.
module video_raster_counter #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int CW      = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          count_i,
  output logic [CW-1:0] h_o,
  output logic [CW-1:0] v_o,
  output logic [CW-1:0] h_next_o,
  output logic [CW-1:0] v_next_o,
  output logic          fe_o
);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          h_wrap;
  logic          v_last;

  assign h_wrap = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);
  assign fe_o   = count_i & h_wrap & v_last;

  // Next counter values: advance while counting, otherwise park at the origin.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    h_d = '0;
    v_d = '0;
    if (count_i) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      v_d = v_q;
      if (h_wrap) v_d = v_last ? '0 : v_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o      = h_q;
  assign v_o      = v_q;
  assign h_next_o = h_d;
  assign v_next_o = v_d;

endmodule

// File: rtl/video_timing_controller.sv
// Raster timing generator and front/back buffer swap controller.
// Drives hsync/vsync/blank and pixel coordinates, swaps the scanned-out
// base address only at frame end, and raises a sticky swap interrupt.
module video_timing_controller
  import video_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CW       = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   ctrl,
  input  logic [31:0]   back_base,
  input  logic          irq_ack,
  output logic          hsync,
  output logic          vsync,
  output logic          blank_n,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic [31:0]   front_base,
  output logic [15:0]   frame_count,
  output logic          swap_pending,
  output logic          swap_done,
  output logic          irq
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [1:0]    rst_sync_q;
  logic          rst_n;
  logic [1:0]    state_q, state_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          blank_n_q, blank_n_d;
  logic [31:0]   front_base_q, front_base_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          swap_pending_q, swap_pending_d;
  logic          swap_prev_q;
  logic          irq_q, irq_d;
  logic [CW-1:0] h_cur, v_cur, h_next, v_next;
  logic          fe;
  logic          scanning;
  logic          swap_rise;
  logic          do_swap;
  logic          unused_ctrl;

  assign unused_ctrl = ^ctrl[31:3];

  // Reset asserts immediately but releases on a clock edge, two flops later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign scanning = (state_q != ST_IDLE);

  video_raster_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .CW      (CW)
  ) u_raster (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_i  (scanning),
    .h_o      (h_cur),
    .v_o      (v_cur),
    .h_next_o (h_next),
    .v_next_o (v_next),
    .fe_o     (fe)
  );

  // Scan-out FSM: a re-enable while draining wins over the frame-end stop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ctrl[CTRL_EN]) state_d = ST_RUN;
      ST_RUN:   if (!ctrl[CTRL_EN]) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (ctrl[CTRL_EN]) state_d = ST_RUN;
        else if (fe)       state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Sync/blank decode from the counters' next values so they register in step.
  always_comb begin
    blank_n_d = 1'b0;
    hsync_d   = ~SYNC_POL;
    vsync_d   = ~SYNC_POL;
    if (state_d != ST_IDLE) begin
      blank_n_d = (h_next < H_ACT_C) && (v_next < V_ACT_C);
      if (h_next >= HS_BEG && h_next < HS_END) hsync_d = SYNC_POL;
      if (v_next >= VS_BEG && v_next < VS_END) vsync_d = SYNC_POL;
    end
  end

  // Swap handshake, frame counter and interrupt.
  assign swap_rise = ctrl[CTRL_SWAP] & ~swap_prev_q;
  assign do_swap   = fe & swap_pending_q;

  always_comb begin
    // A rising edge on the frame-end cycle itself re-arms for the following frame.
    swap_pending_d = (swap_pending_q & ~fe) | (swap_rise & scanning);
    front_base_d   = do_swap ? back_base : front_base_q;
    frame_count_d  = fe ? frame_count_q + 16'd1 : frame_count_q;
    // A new set beats a simultaneous acknowledge.
    irq_d          = (do_swap & ctrl[CTRL_IRQEN]) | (irq_q & ~irq_ack);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      hsync_q        <= ~SYNC_POL;
      vsync_q        <= ~SYNC_POL;
      blank_n_q      <= 1'b0;
      front_base_q   <= '0;
      frame_count_q  <= '0;
      swap_pending_q <= 1'b0;
      swap_prev_q    <= 1'b0;
      irq_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      blank_n_q      <= blank_n_d;
      front_base_q   <= front_base_d;
      frame_count_q  <= frame_count_d;
      swap_pending_q <= swap_pending_d;
      swap_prev_q    <= ctrl[CTRL_SWAP];
      irq_q          <= irq_d;
    end
  end

  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign blank_n      = blank_n_q;
  assign pix_x        = h_cur;
  assign pix_y        = v_cur;
  assign front_base   = front_base_q;
  assign frame_count  = frame_count_q;
  assign swap_pending = swap_pending_q;
  assign swap_done    = do_swap;
  assign irq          = irq_q;

endmodule

// File: tb/tb_video_timing_controller.sv
// Self-checking bench for video_timing_controller on a tiny 14x7 raster.
module tb_video_timing_controller;

  localparam int HA = 8, HFP = 2, HS = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;  // 14
  localparam int VT = VA + VFP + VS + VBP;  // 7
  localparam int FRAME = HT * VT;           // 98

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ctrl;
  logic [31:0] back_base;
  logic        irq_ack;
  logic        hsync, vsync, blank_n;
  logic [9:0]  pix_x, pix_y;
  logic [31:0] front_base;
  logic [15:0] frame_count;
  logic        swap_pending, swap_done, irq;

  int checks = 0;
  int errors = 0;

  video_timing_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .CW(10)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ctrl         (ctrl),
    .back_base    (back_base),
    .irq_ack      (irq_ack),
    .hsync        (hsync),
    .vsync        (vsync),
    .blank_n      (blank_n),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .front_base   (front_base),
    .frame_count  (frame_count),
    .swap_pending (swap_pending),
    .swap_done    (swap_done),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Reference model: raster position as one linear index into the frame.
  bit          m_scan, m_stop, m_pend, m_prev_swap, m_irq;
  int          m_pos;
  logic [31:0] m_front;
  logic [15:0] m_fc;

  task automatic model_reset();
    m_scan = 0; m_stop = 0; m_pend = 0; m_prev_swap = 0; m_irq = 0;
    m_pos = 0; m_front = '0; m_fc = '0;
  endtask

  task automatic model_step();
    bit en, fe, rise, swap;
    en   = ctrl[0];
    fe   = m_scan && (m_pos == FRAME - 1);
    rise = ctrl[1] && !m_prev_swap;
    swap = fe && m_pend;
    if (swap) m_front = back_base;
    m_irq  = (swap && ctrl[2]) || (m_irq && !irq_ack);
    m_pend = (m_pend && !fe) || (rise && m_scan);
    if (fe) m_fc = m_fc + 16'd1;
    m_prev_swap = ctrl[1];
    if (m_scan) m_pos = (m_pos + 1) % FRAME;
    if (!m_scan) begin
      if (en) begin m_scan = 1; m_stop = 0; end
    end else if (m_stop) begin
      if (en) m_stop = 0;
      else if (fe) begin m_scan = 0; m_pos = 0; end
    end else if (!en) begin
      m_stop = 1;
    end
  endtask

  function automatic logic [127:0] model_vec();
    int h, v;
    bit b, hs, vs, done;
    h = 0; v = 0; b = 0; hs = 1; vs = 1;
    if (m_scan) begin
      h  = m_pos % HT;
      v  = m_pos / HT;
      b  = (h < HA) && (v < VA);
      hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
      vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
    end
    done = m_scan && (m_pos == FRAME - 1) && m_pend;
    return {54'd0, 10'(h), 10'(v), b, hs, vs, m_front, m_fc, m_pend, done, m_irq};
  endfunction

  function automatic logic [127:0] dut_vec();
    return {54'd0, pix_x, pix_y, blank_n, hsync, vsync, front_base, frame_count,
            swap_pending, swap_done, irq};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: advance the model with the current inputs, then compare everything.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("cycle_vs_model", dut_vec(), model_vec());
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    while ((!m_scan || m_pos != target) && n < 300) begin
      tick();
      n++;
    end
    check("run_to_pos", 32'(pix_x) + 32'(HT) * 32'(pix_y), 32'(target));
  endtask

  typedef struct {
    int          adv;
    logic [31:0] ctl;
    logic [9:0]  x, y;
    logic        b, hs, vs;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl[$];
  int   swaps;
  bit   r_en, r_swap, r_irqen;

  initial begin
    // Raster timing after enable: adv cycles, then expected outputs.
    tbl.push_back('{1,  32'h1, 10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 16'd0});
    tbl.push_back('{8,  32'h1, 10'd8,  10'd0, 1'b0, 1'b1, 1'b1, 16'd0});
    tbl.push_back('{2,  32'h1, 10'd10, 10'd0, 1'b0, 1'b0, 1'b1, 16'd0});
    tbl.push_back('{1,  32'h1, 10'd11, 10'd0, 1'b0, 1'b0, 1'b1, 16'd0});
    tbl.push_back('{1,  32'h1, 10'd12, 10'd0, 1'b0, 1'b1, 1'b1, 16'd0});
    tbl.push_back('{1,  32'h1, 10'd13, 10'd0, 1'b0, 1'b1, 1'b1, 16'd0});
    tbl.push_back('{1,  32'h1, 10'd0,  10'd1, 1'b1, 1'b1, 1'b1, 16'd0});
    tbl.push_back('{56, 32'h1, 10'd0,  10'd5, 1'b0, 1'b1, 1'b0, 16'd0});
    tbl.push_back('{14, 32'h1, 10'd0,  10'd6, 1'b0, 1'b1, 1'b1, 16'd0});
    tbl.push_back('{13, 32'h1, 10'd13, 10'd6, 1'b0, 1'b1, 1'b1, 16'd0});
    tbl.push_back('{1,  32'h1, 10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 16'd1});
    tbl.push_back('{98, 32'h1, 10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 16'd2});

    reset_n = 1'b0; ctrl = '0; back_base = '0; irq_ack = 1'b0;
    model_reset();
    #23 reset_n = 1'b1;
    repeat (3) tick();
    check("reset_state", dut_vec(), {54'd0, 10'd0, 10'd0, 3'b011, 32'd0, 16'd0, 3'b000});

    // 1. raster timing table
    foreach (tbl[i]) begin
      ctrl = tbl[i].ctl;
      repeat (tbl[i].adv) tick();
      check($sformatf("raster_%0d", i), {pix_x, pix_y, blank_n, hsync, vsync, frame_count},
            {tbl[i].x, tbl[i].y, tbl[i].b, tbl[i].hs, tbl[i].vs, tbl[i].fc});
    end

    // 2. basic swap with interrupt
    back_base = 32'h1000; ctrl = 32'h5;
    run_to(20);
    ctrl = 32'h7; tick();
    check("swap_pending_set", swap_pending, 1'b1);
    ctrl = 32'h5;
    run_to(FRAME - 1);
    check("swap_done_at_fe", {swap_done, front_base}, {1'b1, 32'h0});
    tick();
    check("swap_after_fe", {front_base, swap_done, swap_pending, irq}, {32'h1000, 3'b001});
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("irq_acked", irq, 1'b0);

    // 3. level held across frames swaps once; a fresh edge swaps again
    back_base = 32'h2000; ctrl = 32'h7; tick();
    swaps = 0;
    repeat (3 * FRAME) begin
      tick();
      if (swap_done) swaps++;
    end
    check("held_level_one_swap", {32'(swaps), front_base}, {32'd1, 32'h2000});
    ctrl = 32'h5; tick();
    back_base = 32'h3000; ctrl = 32'h7; tick();
    check("rearm_pending", swap_pending, 1'b1);
    run_to(FRAME - 1);
    check("rearm_swap_done", swap_done, 1'b1);
    tick();
    check("rearm_front", front_base, 32'h3000);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;

    // 4. disable drains to frame end; re-enable while draining keeps counting
    ctrl = 32'h1;
    run_to(HT + 3);
    ctrl = 32'h0; tick();
    run_to(FRAME - 1);
    tick();
    check("idle_after_drain", {pix_x, pix_y, blank_n, hsync, vsync}, {10'd0, 10'd0, 3'b011});
    repeat (5) tick();
    check("idle_holds", {pix_x, pix_y, blank_n}, {10'd0, 10'd0, 1'b0});
    ctrl = 32'h1; tick();
    check("restart_origin", {pix_x, pix_y, blank_n}, {10'd0, 10'd0, 1'b1});
    run_to(30);
    ctrl = 32'h0; tick();
    run_to(39);
    ctrl = 32'h1; tick();
    check("reenable_no_disturb", {pix_x, pix_y}, {10'd12, 10'd2});
    run_to(FRAME - 1);
    tick();
    check("reenable_keeps_running", {pix_x, pix_y, blank_n}, {10'd0, 10'd0, 1'b1});

    // 5. irq set beats simultaneous ack; swap edge on the FE cycle stays pending
    back_base = 32'h4000; ctrl = 32'h5; tick();
    ctrl = 32'h7; tick();
    ctrl = 32'h5;
    run_to(FRAME - 1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("irq_set_wins", {irq, front_base}, {1'b1, 32'h4000});
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("irq_cleared", irq, 1'b0);
    run_to(FRAME - 1);
    ctrl = 32'h7; tick();
    check("fe_edge_kept", {swap_pending, swap_done, front_base}, {2'b10, 32'h4000});
    back_base = 32'h5000;
    run_to(FRAME - 1);
    check("fe_edge_swap_done", swap_done, 1'b1);
    tick();
    check("fe_edge_front", {front_base, swap_pending}, {32'h5000, 1'b0});

    // 6. asynchronous mid-frame reset, then frame_count wrap
    ctrl = 32'h1;
    run_to(2 * HT + 5);
    #3 reset_n = 1'b0;
    #1;
    check("async_reset", dut_vec(), {54'd0, 10'd0, 10'd0, 3'b011, 32'd0, 16'd0, 3'b000});
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1; ctrl = 32'h0;
    repeat (3) tick();
    ctrl = 32'h1;
    run_to(50);
    force dut.frame_count_q = 16'hFFFF;
    m_fc = 16'hFFFF;
    tick();
    release dut.frame_count_q;
    run_to(FRAME - 1);
    tick();
    check("frame_count_wrap", frame_count, 16'h0000);

    // Randomised traffic against the model
    r_en = 1; r_swap = 0; r_irqen = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) r_en = ~r_en;
      if ($urandom_range(0, 59) == 0) r_swap = ~r_swap;
      if ($urandom_range(0, 99) == 0) r_irqen = ~r_irqen;
      if ($urandom_range(0, 39) == 0) back_base = $urandom;
      irq_ack = ($urandom_range(0, 19) == 0);
      ctrl = {29'($urandom), r_irqen, r_swap, r_en};
      tick();
    end
    irq_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
